// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctrl_if
//  Purpose  : Word-addressed register port between the bridge and int_ctrl.
//             The bridge performs the range decode. The slave decodes only
//             Addr[1:0].
//  Signals  : Addr[29:0] word address, WE write strobe, Din write data,
//             Dout combinational read data
//  Revision : 1.0  initial release
// ============================================================================
interface int_ctrl_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctrl
//  Purpose  : Memory-mapped interrupt controller. It applies a per-source
//             level/edge mode and an enable mask. It latches edge events until
//             software clears them with W1C or EOI. It reports the
//             highest-index pending source through the ID register.
//  Ports    : clk      system clock
//             reset    asynchronous active-high reset
//             src_irq  raw interrupt requests, one bit per source
//             bus      register port (Addr/WE/Din/Dout)
//             HWInt    masked pending vector to the CPU
//             irq_any  OR of HWInt
//  Registers: 0 MODE (RW), 1 MASK (RW), 2 PEND (R/W1C), 3 ID (R, write = EOI)
//  Revision : 1.0  initial release
// ============================================================================
module int_ctrl #(
    parameter int N_SRC = 6
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [N_SRC-1:0] src_irq,
    int_ctrl_if.slave             bus,
    output logic      [N_SRC-1:0] HWInt,
    output logic                  irq_any
);

    localparam logic [1:0] C_A_MODE = 2'd0;
    localparam logic [1:0] C_A_MASK = 2'd1;
    localparam logic [1:0] C_A_PEND = 2'd2;
    localparam logic [1:0] C_A_ID   = 2'd3;

    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] src_q;

    logic [N_SRC-1:0] hit_w;
    logic             valid_w;
    logic [2:0]       idx_w;
    logic [N_SRC-1:0] rise_w;
    logic [N_SRC-1:0] clr_w;
    logic             we_mode_w, we_mask_w, we_pend_w, we_id_w;

    assign hit_w   = pend_q & mask_q;
    assign valid_w = |hit_w;
    assign rise_w  = src_irq & ~src_q;

    assign we_mode_w = bus.WE && (bus.Addr[1:0] == C_A_MODE);
    assign we_mask_w = bus.WE && (bus.Addr[1:0] == C_A_MASK);
    assign we_pend_w = bus.WE && (bus.Addr[1:0] == C_A_PEND);
    assign we_id_w   = bus.WE && (bus.Addr[1:0] == C_A_ID);

    // The ascending scan lets a higher index overwrite a lower one, so the
    // highest set index wins.
    always_comb begin
        idx_w = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (hit_w[i]) idx_w = 3'(i);
        end
    end

    // Clear requests come from W1C data or from the EOI of the reported source.
    // Level-mode bits ignore clr, because they follow the source directly.
    always_comb begin
        clr_w = '0;
        if (we_pend_w) clr_w = clr_w | bus.Din[N_SRC-1:0];
        if (we_id_w && valid_w) clr_w = clr_w | (N_SRC'(1) << idx_w);
    end

    assign mode_d = we_mode_w ? bus.Din[N_SRC-1:0] : mode_q;
    assign mask_d = we_mask_w ? bus.Din[N_SRC-1:0] : mask_q;

    // The next-state logic uses the MODE value held before this cycle's write.
    // A rise wins over a clear, so a new event is never lost.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
            assign pend_d[gi] = mode_q[gi] ? (rise_w[gi] | (pend_q[gi] & ~clr_w[gi]))
                                           : src_irq[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= '0;
            mask_q <= '1;
            pend_q <= '0;
            src_q  <= '0;
        end else begin
            mode_q <= mode_d;
            mask_q <= mask_d;
            pend_q <= pend_d;
            src_q  <= src_irq;
        end
    end

    always_comb begin
        bus.Dout = 32'd0;
        case (bus.Addr[1:0])
            C_A_MODE: bus.Dout = {{(32-N_SRC){1'b0}}, mode_q};
            C_A_MASK: bus.Dout = {{(32-N_SRC){1'b0}}, mask_q};
            C_A_PEND: bus.Dout = {{(32-N_SRC){1'b0}}, pend_q};
            C_A_ID:   bus.Dout = {valid_w, 28'd0, idx_w};
            default:  bus.Dout = 32'd0;
        endcase
    end

    assign HWInt   = hit_w;
    assign irq_any = valid_w;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_ctrl
//  Purpose  : Directed self-checking bench for int_ctrl. Each step pushes its
//             expected value into a scoreboard queue. The value is popped and
//             compared when the corresponding DUT output is sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_int_ctrl;

    localparam int N_SRC = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_SRC-1:0] src_irq;
    logic [N_SRC-1:0] HWInt;
    logic             irq_any;

    int_ctrl_if bus ();

    int_ctrl #(.N_SRC(N_SRC)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .bus     (bus.slave),
        .HWInt   (HWInt),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic push_exp(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = {28'd0, a};
        bus.Din  = d;
        bus.WE   = 1'b1;
        tick();
        bus.WE   = 1'b0;
    endtask

    task automatic rd_chk(input string t, input logic [1:0] a, input logic [31:0] e);
        bus.Addr = {28'd0, a};
        push_exp(t, e);
        #1;
        pop_cmp(bus.Dout);
    endtask

    task automatic hw_chk(input string t, input logic [31:0] e);
        push_exp(t, e);
        pop_cmp({26'd0, HWInt});
    endtask

    initial begin
        reset    = 1'b1;
        src_irq  = 6'b000100;
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.Din  = '0;

        // Reset defaults
        tick();
        hw_chk("rst_hwint", 32'h0);
        rd_chk("rst_mode", 2'd0, 32'h0);
        rd_chk("rst_mask", 2'd1, 32'h3F);
        tick();
        rd_chk("rst_pend", 2'd2, 32'h0);
        rd_chk("rst_id",   2'd3, 32'h0);
        reset = 1'b0;
        tick();
        hw_chk("rel_hwint", 32'h04);
        rd_chk("rel_id", 2'd3, 32'h80000002);

        // Level pass-through and mask
        wr(2'd1, 32'h3B);
        hw_chk("mask_hwint", 32'h0);
        rd_chk("mask_id", 2'd3, 32'h0);
        src_irq = 6'h00;
        wr(2'd1, 32'h3F);
        hw_chk("unmask_hwint", 32'h0);

        // Edge latch and W1C
        wr(2'd0, 32'h01);
        src_irq = 6'h01;
        tick();
        src_irq = 6'h00;
        rd_chk("edge_pend", 2'd2, 32'h01);
        tick();
        rd_chk("edge_hold", 2'd2, 32'h01);
        wr(2'd2, 32'h01);
        rd_chk("w1c_pend", 2'd2, 32'h00);
        src_irq = 6'h01;
        tick();
        rd_chk("held_first", 2'd2, 32'h01);
        wr(2'd2, 32'h01);
        for (int i = 0; i < 8; i++) tick();
        rd_chk("held_once", 2'd2, 32'h00);
        src_irq = 6'h00;

        // Clear/rise collision
        wr(2'd0, 32'h03);
        src_irq = 6'h02;
        tick();
        src_irq = 6'h00;
        tick();
        rd_chk("coll_setup", 2'd2, 32'h02);
        src_irq = 6'h02;
        wr(2'd2, 32'h02);
        rd_chk("coll_pend", 2'd2, 32'h02);
        src_irq = 6'h00;
        wr(2'd2, 32'h02);
        rd_chk("coll_clr", 2'd2, 32'h00);

        // Priority and EOI
        wr(2'd0, 32'h07);
        src_irq = 6'h05;
        tick();
        src_irq = 6'h00;
        tick();
        rd_chk("prio_id", 2'd3, 32'h80000002);
        wr(2'd3, 32'h0);
        rd_chk("eoi1_pend", 2'd2, 32'h01);
        rd_chk("eoi1_id",   2'd3, 32'h80000000);
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk("eoi2_id", 2'd3, 32'h0);
        push_exp("eoi2_any", 32'h0);
        pop_cmp({31'd0, irq_any});

        // Masked latch
        wr(2'd0, 32'h02);
        wr(2'd1, 32'h3D);
        src_irq = 6'h02;
        tick();
        src_irq = 6'h00;
        tick();
        hw_chk("mlatch_hwint", 32'h0);
        rd_chk("mlatch_pend", 2'd2, 32'h02);
        wr(2'd1, 32'h3F);
        hw_chk("unmask_edge", 32'h02);
        push_exp("unmask_any", 32'h1);
        pop_cmp({31'd0, irq_any});

        // Asynchronous reset mid-operation
        #1 reset = 1'b1;
        #1;
        hw_chk("arst_hwint", 32'h0);
        rd_chk("arst_mask", 2'd1, 32'h3F);
        rd_chk("arst_mode", 2'd0, 32'h0);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
